hilo_ctrl: RTL and testbench
============================

# hilo_ctrl

Sequencer and HI/LO register bank downstream of the divider and multiplier in the MIPS datapath. It accepts DIV, MULT, MTHI and MTLO operations from the control unit and launches the divider or multiplier. It waits a fixed latency, then captures high/low into the architectural HI/LO registers. It also reports busy to stall the pipeline, signals completion, and raises a divide-by-zero exception pulse.

## Interface

Parameters:
- DIV_LATENCY, 34: cycles from the accepting edge to the edge that captures divider results.
- MUL_LATENCY, 33: same, for the multiplier.
- CNT_W, 6: latency counter width; must hold max(DIV_LATENCY, MUL_LATENCY).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- op_valid  in  1  an operation is presented this cycle.
- op  in  3  opcode: NONE=0, DIV=1, MULT=2, MTHI=3, MTLO=4; values 5–7 are ignored.
- wdata  in  32  source value for MTHI/MTLO.
- div_high, div_low  in  32 each  divider remainder/quotient.
- div_div0  in  1  divider's combinational divisor==0 flag.
- mul_high, mul_low  in  32 each  multiplier product halves.
- div_start  out  1  combinational start pulse to the divider.
- mul_start  out  1  combinational start pulse to the multiplier.
- hi, lo  out  32 each  architectural HI/LO registers.
- busy  out  1  high while a DIV or MULT is in flight.
- done  out  1  registered one-cycle pulse; HI/LO were just written by DIV or MULT.
- div0_exc  out  1  registered one-cycle pulse; a DIV was rejected because of divisor 0.

## Operation

- Reset: state=IDLE, cnt=0, hi=0, lo=0, busy=0, done=0, div0_exc=0, div_start=0, mul_start=0.
- States: IDLE, DIV_RUN, MUL_RUN. busy = (state != IDLE).
- Accept: an op is accepted only when op_valid is high and state is IDLE. An op presented while busy is dropped, not queued. Upstream must hold the op while busy is high.
- DIV accepted with div_div0=0:
  - div_start=1 in that same cycle.
  - On the edge: state→DIV_RUN, cnt←1.
- DIV accepted with div_div0=1:
  - No div_start.
  - State stays IDLE; hi/lo unchanged.
  - div0_exc=1 for the following cycle.
- MULT accepted: mul_start=1 in that same cycle; state→MUL_RUN, cnt←1.
- MTHI: hi←wdata on the accepting edge. MTLO: lo←wdata on the accepting edge. Neither pulses done.
- In RUN states, cnt increments each edge.
- Capture edge: when cnt==LATENCY (DIV_LATENCY or MUL_LATENCY) on an edge:
  - hi←*_high, lo←*_low.
  - state→IDLE, cnt←0.
  - done=1 for the next cycle.
- Results are taken verbatim; sign correction is the arithmetic unit's job.
- div_start and mul_start are never both high, and are never high outside IDLE.

## Timing

- Accept at edge E0. hi/lo are updated at E0+DIV_LATENCY (or E0+MUL_LATENCY). done and busy=0 are visible in the cycle after that edge.
- busy is high for exactly LATENCY cycles per DIV/MULT.
- Back-to-back: a new op may be accepted in the same cycle that done is high.
- MTHI/MTLO: 1-cycle effect; hi/lo are readable in the next cycle; busy stays 0.
- Reset mid-operation: asynchronous return to reset values. No done pulse, no capture. The arithmetic units share rst.
- div0_exc and done are never high in the same cycle.

## Structure

- Shared package hilo_pkg:
  - op encoding, as an enum of width 3;
  - state enum;
  - default latency constants DIV_LATENCY_DEF=34 and MUL_LATENCY_DEF=33.
- Single module; the counter and FSM stay inline. The divider and multiplier are instantiated by the parent datapath, not inside this block.

## Test plan

- Reset values: assert rst mid-cycle → hi=lo=0, busy=0 immediately. Release, then idle 5 cycles → outputs stable at 0.
- DIV 100/7 with a golden divider model → div_start is a 1-cycle pulse. busy=1 for 34 cycles, then hi=2, lo=14, done pulsed once.
- DIV with divisor 0 and hi=0xAAAA0000 preloaded via MTHI → no div_start, div0_exc pulses once, hi unchanged, busy never 1.
- MULT 0x10000×0x10000 → after 33 cycles hi=1, lo=0, done pulsed once.
- MTLO 0x1234 presented mid-DIV, held until busy drops → ignored while busy. Written at the first idle edge, then overwritten by the DIV result only if the DIV finished later (it does not) → final lo=0x1234.
- Reset asserted at cycle 10 of a DIV → no done, hi/lo=0, state IDLE. A new DIV is accepted normally afterwards.

Source files
------------

// File: rtl/hilo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_pkg
//  Description : Shared types and constants for the HI/LO sequencer:
//                operation encoding, FSM state encoding, default latencies.
//  Revision    : 1.0  initial release
// ============================================================================
package hilo_pkg;

    // Operation codes presented by the control unit (5..7 are ignored)
    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_DIV  = 3'd1,
        OP_MULT = 3'd2,
        OP_MTHI = 3'd3,
        OP_MTLO = 3'd4
    } op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIV_RUN = 2'd1,
        ST_MUL_RUN = 2'd2
    } state_e;

    // Default arithmetic-unit latencies (accepting edge to capture edge)
    localparam int DIV_LATENCY_DEF = 34;
    localparam int MUL_LATENCY_DEF = 33;

endpackage : hilo_pkg
`default_nettype wire

// File: rtl/hilo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_ctrl
//  Description : Launches the divider / multiplier, waits a fixed latency,
//                captures their high/low results into the architectural
//                HI/LO registers. Handles MTHI/MTLO, reports busy, a done
//                pulse and a divide-by-zero exception pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module hilo_ctrl
    import hilo_pkg::*;
#(
    parameter int DIV_LATENCY = DIV_LATENCY_DEF,
    parameter int MUL_LATENCY = MUL_LATENCY_DEF,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] wdata,
    input  logic [31:0] div_high,
    input  logic [31:0] div_low,
    input  logic        div_div0,
    input  logic [31:0] mul_high,
    input  logic [31:0] mul_low,
    output logic        div_start,
    output logic        mul_start,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div0_exc
);

    localparam logic [CNT_W-1:0] c_div_lat = CNT_W'(DIV_LATENCY);
    localparam logic [CNT_W-1:0] c_mul_lat = CNT_W'(MUL_LATENCY);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [31:0]      hi_q,    hi_d;
    logic [31:0]      lo_q,    lo_d;
    logic             done_q,  done_d;
    logic             div0_exc_q, div0_exc_d;

    // State, counter, HI/LO and pulse registers; asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div0_exc_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div0_exc_q <= div0_exc_d;
        end
    end

    // Next-state, capture and start-pulse decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div0_exc_d = 1'b0;
        div_start  = 1'b0;
        mul_start  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Ops are only accepted here; anything presented while busy is dropped
                if (op_valid) begin
                    case (op)
                        OP_DIV: begin
                            if (div_div0) begin
                                // Divisor zero: reject, never start the divider
                                div0_exc_d = 1'b1;
                            end else begin
                                div_start = 1'b1;
                                state_d   = ST_DIV_RUN;
                                cnt_d     = c_cnt_one;
                            end
                        end
                        OP_MULT: begin
                            mul_start = 1'b1;
                            state_d   = ST_MUL_RUN;
                            cnt_d     = c_cnt_one;
                        end
                        OP_MTHI: hi_d = wdata;
                        OP_MTLO: lo_d = wdata;
                        default: ;
                    endcase
                end
            end

            ST_DIV_RUN: begin
                if (cnt_q == c_div_lat) begin
                    hi_d    = div_high;
                    lo_d    = div_low;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end

            ST_MUL_RUN: begin
                if (cnt_q == c_mul_lat) begin
                    hi_d    = mul_high;
                    lo_d    = mul_low;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign div0_exc = div0_exc_q;

endmodule : hilo_ctrl
`default_nettype wire

// File: tb/tb_hilo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hilo_ctrl
//  Description : Directed testbench for hilo_ctrl with a golden divider and
//                multiplier model and a done/div0_exc scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hilo_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] wdata = '0;
    logic [31:0] div_a = '0, div_b = 32'd1;
    logic [31:0] mul_a = '0, mul_b = '0;
    logic [31:0] div_high, div_low, mul_high, mul_low;
    logic        div_div0;
    logic        div_start, mul_start, busy, done, div0_exc;
    logic [31:0] hi, lo;
    logic [63:0] w_prod;

    // Golden arithmetic units: results held stable while operands are held
    assign div_div0 = (div_b == 32'd0);
    assign div_high = div_div0 ? 32'd0 : div_a % div_b;
    assign div_low  = div_div0 ? 32'd0 : div_a / div_b;
    assign w_prod   = {32'd0, mul_a} * {32'd0, mul_b};
    assign mul_high = w_prod[63:32];
    assign mul_low  = w_prod[31:0];

    hilo_ctrl dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .wdata(wdata),
        .div_high(div_high), .div_low(div_low), .div_div0(div_div0),
        .mul_high(mul_high), .mul_low(mul_low),
        .div_start(div_start), .mul_start(mul_start),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div0_exc(div0_exc)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_exc;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pop and compare on every done / div0_exc pulse
    always @(negedge clk) begin
        if (!rst) begin
            if (div_start && mul_start) begin
                n_err++;
                $display("FAIL start_overlap: got 1 expected 0");
            end
            if (done && div0_exc) begin
                n_err++;
                $display("FAIL done_exc_overlap: got 1 expected 0");
            end
            if (done || div0_exc) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_pulse: got done=%0d exc=%0d expected none", done, div0_exc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pulse_kind", {63'd0, div0_exc}, {63'd0, e.is_exc});
                    chk("result_hi", {32'd0, hi}, {32'd0, e.hi});
                    chk("result_lo", {32'd0, lo}, {32'd0, e.lo});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an op for one cycle; report the start strobes seen in that cycle
    task automatic issue(input logic [2:0] o, input logic [31:0] wd,
                         output logic ds, output logic ms);
        op_valid = 1'b1;
        op       = o;
        wdata    = wd;
        @(negedge clk);
        ds = div_start;
        ms = mul_start;
        step();
        op_valid = 1'b0;
        op       = 3'd0;
    endtask

    // Count busy cycles following an accept edge, bounded
    task automatic count_busy(output int n);
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic ds, ms;
        int   nb;
        bit   seen_busy;

        // ---------------- Reset values ----------------
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        chk("rst_flags", {59'd0, busy, done, div0_exc, div_start, mul_start}, 64'd0);
        issue(3'd3, 32'h55, ds, ms);
        chk("mthi_pre", {32'd0, hi}, 64'h55);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_hi", {32'd0, hi}, 64'd0);
        chk("async_rst_busy", {63'd0, busy}, 64'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_zero", {hi, lo | {25'd0, busy, done, div0_exc, div_start, mul_start, 2'd0}}, 64'd0);
        end

        // ---------------- DIV 100/7 ----------------
        div_a = 32'd100; div_b = 32'd7;
        exp_q.push_back('{is_exc: 1'b0, hi: 32'd2, lo: 32'd14});
        issue(3'd1, 32'd0, ds, ms);
        chk("div_start", {62'd0, ds, ms}, 64'b10);
        chk("div_start_pulse", {63'd0, div_start}, 64'd0);
        count_busy(nb);
        chk("div_busy_cycles", 64'(nb), 64'd34);
        step();

        // ---------------- DIV by zero with HI preloaded ----------------
        issue(3'd3, 32'hAAAA0000, ds, ms);
        chk("mthi_hi", {32'd0, hi}, 64'hAAAA0000);
        chk("mthi_busy", {63'd0, busy}, 64'd0);
        div_a = 32'd9; div_b = 32'd0;
        exp_q.push_back('{is_exc: 1'b1, hi: 32'hAAAA0000, lo: 32'd14});
        seen_busy = busy;
        issue(3'd1, 32'd0, ds, ms);
        chk("div0_no_start", {62'd0, ds, ms}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen_busy |= busy;
        end
        chk("div0_never_busy", {63'd0, seen_busy}, 64'd0);
        chk("div0_hi_kept", {32'd0, hi}, 64'hAAAA0000);
        step();

        // ---------------- MULT 0x10000 x 0x10000 ----------------
        mul_a = 32'h10000; mul_b = 32'h10000;
        exp_q.push_back('{is_exc: 1'b0, hi: 32'd1, lo: 32'd0});
        issue(3'd2, 32'd0, ds, ms);
        chk("mul_start", {62'd0, ds, ms}, 64'b01);
        count_busy(nb);
        chk("mul_busy_cycles", 64'(nb), 64'd33);
        step();

        // ---------------- MTLO held during DIV ----------------
        div_a = 32'd1000; div_b = 32'd3;
        exp_q.push_back('{is_exc: 1'b0, hi: 32'd1, lo: 32'd333});
        issue(3'd1, 32'd0, ds, ms);
        repeat (5) step();
        op_valid = 1'b1; op = 3'd4; wdata = 32'h1234;
        nb = 0;
        while (busy && nb < 200) begin
            step();
            nb++;
        end
        chk("mtlo_ignored_busy", {32'd0, lo}, 64'd333);
        step();
        op_valid = 1'b0; op = 3'd0;
        chk("mtlo_final_lo", {32'd0, lo}, 64'h1234);
        chk("mtlo_hi_kept", {32'd0, hi}, 64'd1);
        step();

        // ---------------- Reset mid-DIV ----------------
        div_a = 32'd100; div_b = 32'd7;
        issue(3'd1, 32'd0, ds, ms);
        repeat (9) step();
        #3 rst = 1'b1;
        #1;
        chk("midrst_hi_lo", {hi, lo}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        step();
        rst = 1'b0;
        repeat (40) step();
        chk("midrst_no_done", {32'd0, hi}, 64'd0);

        // New DIV after reset: 50/6
        div_a = 32'd50; div_b = 32'd6;
        exp_q.push_back('{is_exc: 1'b0, hi: 32'd2, lo: 32'd8});
        issue(3'd1, 32'd0, ds, ms);
        chk("post_rst_div_start", {62'd0, ds, ms}, 64'b10);
        count_busy(nb);
        chk("post_rst_busy_cycles", 64'(nb), 64'd34);
        repeat (3) step();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_hilo_ctrl
`default_nettype wire
